// File: rtl/grid_game_engine.sv
// -----------------------------------------------------------------------------
// grid_game_engine
//
// Two-player N x N "k in a row" game core (tic-tac-toe and bigger variants).
// Holds the board, the cursor, the side to move, a per-turn timer and the
// two win counters. After every placement a small sequential scanner walks
// the four line directions out from the new mark, one neighbour per cycle,
// and decides between WIN, DRAW or handing the move to the other side.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   btn_next   pulse: advance the cursor (PLAY only)
//   btn_sel    pulse: place the current player's mark at the cursor
//   new_game   pulse: clear the board, keep the scores
//   tick_1s    pulse: one-second tick for the turn timer
//   rd_addr    renderer cell index (row*N+col)
//   rd_data    registered cell contents at rd_addr: 00 empty, 01 X, 10 O
//   cursor     current cursor cell index
//   player     side to move: 0 = X, 1 = O
//   state      00 PLAY, 01 CHECK, 10 WIN, 11 DRAW
//   winner     01 X, 10 O, 00 none
//   illegal    one-cycle pulse: btn_sel on an occupied cell
//   timeout    one-cycle pulse: the turn expired
//   score_x/o  saturating win counters
// -----------------------------------------------------------------------------
module grid_game_engine #(
   parameter int  N         = 3,
   parameter int  WIN_LEN   = 3,
   parameter int  TURN_SECS = 10,
   localparam int AW        = $clog2(N*N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          btn_next,
   input  logic          btn_sel,
   input  logic          new_game,
   input  logic          tick_1s,
   input  logic [AW-1:0] rd_addr,
   output logic [1:0]    rd_data,
   output logic [AW-1:0] cursor,
   output logic          player,
   output logic [1:0]    state,
   output logic [1:0]    winner,
   output logic          illegal,
   output logic          timeout,
   output logic [7:0]    score_x,
   output logic [7:0]    score_o
);

   localparam int NN = N * N;
   localparam int PW = $clog2(NN + 1);

   localparam logic signed [4:0] N_S  = 5'(N);
   localparam logic [3:0]        WL   = 4'(WIN_LEN);
   localparam logic [7:0]        TS   = 8'(TURN_SECS);
   localparam logic [PW-1:0]     FULL = PW'(NN);
   localparam logic [AW-1:0]     LAST = AW'(NN - 1);

   localparam logic [1:0] S_PLAY  = 2'b00;
   localparam logic [1:0] S_CHECK = 2'b01;
   localparam logic [1:0] S_WIN   = 2'b10;
   localparam logic [1:0] S_DRAW  = 2'b11;

   logic [1:0]        cells [NN];
   logic [7:0]        timer;
   logic [PW-1:0]     placed;

   // Scanner state: origin of the scan, current probe, direction, which
   // half of the line is being walked and the run length found so far.
   logic signed [4:0] base_r, base_c;
   logic signed [4:0] probe_r, probe_c;
   logic [1:0]        dir;
   logic              back;
   logic [3:0]        run;

   logic [1:0]        mark;
   logic signed [4:0] dr, dc, nr, nc;
   logic signed [4:0] cur_row, cur_col;
   logic              in_bounds, hit, rd_ok;
   logic [AW-1:0]     nb_idx, rd_idx;

   // NOTE: every variable driven here gets a default first, so no path
   // through the block can leave a value held and infer a latch.
   always_comb begin
      mark    = player ? 2'b10 : 2'b01;
      cur_row = 5'(int'(cursor) / N);
      cur_col = 5'(int'(cursor) % N);

      dr = 5'sd0;
      dc = 5'sd1;
      case (dir)
         2'd0:    begin dr = 5'sd0; dc = 5'sd1;  end  // horizontal
         2'd1:    begin dr = 5'sd1; dc = 5'sd0;  end  // vertical
         2'd2:    begin dr = 5'sd1; dc = 5'sd1;  end  // main diagonal
         default: begin dr = 5'sd1; dc = -5'sd1; end  // anti-diagonal
      endcase

      if (back) begin
         nr = probe_r - dr;
         nc = probe_c - dc;
      end else begin
         nr = probe_r + dr;
         nc = probe_c + dc;
      end

      in_bounds = (nr >= 5'sd0) && (nr < N_S) && (nc >= 5'sd0) && (nc < N_S);
      nb_idx    = in_bounds ? AW'(int'(nr) * N + int'(nc)) : '0;
      hit       = in_bounds && (cells[nb_idx] == mark);

      // Out-of-range renderer addresses read as empty without indexing
      // past the end of the board.
      rd_ok  = int'(rd_addr) < NN;
      rd_idx = rd_ok ? rd_addr : '0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the board is cleared on reset because the renderer and the
         // draw detection both rely on every cell starting empty.
         for (int i = 0; i < NN; i++) cells[i] <= 2'b00;
         rd_data <= 2'b00;
         cursor  <= '0;
         player  <= 1'b0;
         state   <= S_PLAY;
         winner  <= 2'b00;
         illegal <= 1'b0;
         timeout <= 1'b0;
         score_x <= 8'd0;
         score_o <= 8'd0;
         timer   <= 8'd0;
         placed  <= '0;
         base_r  <= 5'sd0;
         base_c  <= 5'sd0;
         probe_r <= 5'sd0;
         probe_c <= 5'sd0;
         dir     <= 2'd0;
         back    <= 1'b0;
         run     <= 4'd1;
      end else begin
         illegal <= 1'b0;
         timeout <= 1'b0;
         rd_data <= rd_ok ? cells[rd_idx] : 2'b00;

         if (new_game) begin
            for (int i = 0; i < NN; i++) cells[i] <= 2'b00;
            cursor <= '0;
            timer  <= 8'd0;
            winner <= 2'b00;
            player <= 1'b0;
            placed <= '0;
            state  <= S_PLAY;
         end else begin
            case (state)
               S_PLAY: begin
                  if (btn_sel && cells[cursor] == 2'b00) begin
                     // A valid placement also wins over a coincident timer
                     // expiry: the timer simply restarts.
                     cells[cursor] <= mark;
                     placed        <= placed + 1'b1;
                     timer         <= 8'd0;
                     base_r        <= cur_row;
                     base_c        <= cur_col;
                     probe_r       <= cur_row;
                     probe_c       <= cur_col;
                     dir           <= 2'd0;
                     back          <= 1'b0;
                     run           <= 4'd1;
                     state         <= S_CHECK;
                  end else begin
                     if (btn_sel) begin
                        illegal <= 1'b1;
                     end else if (btn_next) begin
                        cursor <= (cursor == LAST) ? '0 : cursor + 1'b1;
                     end
                     if (TURN_SECS > 0 && tick_1s) begin
                        if (timer + 8'd1 == TS) begin
                           timeout <= 1'b1;
                           player  <= ~player;
                           timer   <= 8'd0;
                        end else begin
                           timer <= timer + 8'd1;
                        end
                     end
                  end
               end

               S_CHECK: begin
                  if (hit) begin
                     if (run + 4'd1 >= WL) begin
                        state  <= S_WIN;
                        winner <= mark;
                        if (!player) begin
                           if (score_x != 8'hFF) score_x <= score_x + 8'd1;
                        end else begin
                           if (score_o != 8'hFF) score_o <= score_o + 8'd1;
                        end
                     end else begin
                        run     <= run + 4'd1;
                        probe_r <= nr;
                        probe_c <= nc;
                     end
                  end else if (!back) begin
                     // Forward half ended: walk the opposite way from the origin.
                     back    <= 1'b1;
                     probe_r <= base_r;
                     probe_c <= base_c;
                  end else if (dir == 2'd3) begin
                     if (placed == FULL) begin
                        state <= S_DRAW;
                     end else begin
                        state  <= S_PLAY;
                        player <= ~player;
                     end
                  end else begin
                     dir     <= dir + 2'd1;
                     back    <= 1'b0;
                     run     <= 4'd1;
                     probe_r <= base_r;
                     probe_c <= base_c;
                  end
               end

               default: ;  // WIN and DRAW hold until new_game
            endcase
         end
      end
   end

endmodule

// File: tb/tb_grid_game_engine.sv
// -----------------------------------------------------------------------------
// tb_grid_game_engine
//
// Directed bench for grid_game_engine. Two instances share the control
// inputs: a 3x3 / 3-in-a-row board with a 2-tick turn limit, and a 5x5 /
// 4-in-a-row board with the timer disabled. Each test addresses one
// instance; the other just follows along and is ignored.
// -----------------------------------------------------------------------------
module tb_grid_game_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_next = 1'b0, btn_sel = 1'b0, new_game = 1'b0, tick_1s = 1'b0;
   logic [3:0] rd_addr3 = '0;
   logic [4:0] rd_addr5 = '0;

   logic [1:0] rd_data3, state3, winner3;
   logic [3:0] cursor3;
   logic       player3, illegal3, timeout3;
   logic [7:0] score_x3, score_o3;

   logic [1:0] rd_data5, state5, winner5;
   logic [4:0] cursor5;
   logic       player5, illegal5, timeout5;
   logic [7:0] score_x5, score_o5;

   int errors = 0;
   int checks = 0;
   int c3 = 0;         // bench copy of the 3x3 cursor
   int c5 = 0;         // bench copy of the 5x5 cursor
   int last_cyc = 0;   // cycles spent in CHECK by the last placement

   grid_game_engine #(.N(3), .WIN_LEN(3), .TURN_SECS(2)) dut3 (
      .clk(clk), .rst(rst), .btn_next(btn_next), .btn_sel(btn_sel),
      .new_game(new_game), .tick_1s(tick_1s), .rd_addr(rd_addr3),
      .rd_data(rd_data3), .cursor(cursor3), .player(player3), .state(state3),
      .winner(winner3), .illegal(illegal3), .timeout(timeout3),
      .score_x(score_x3), .score_o(score_o3)
   );

   grid_game_engine #(.N(5), .WIN_LEN(4), .TURN_SECS(0)) dut5 (
      .clk(clk), .rst(rst), .btn_next(btn_next), .btn_sel(btn_sel),
      .new_game(new_game), .tick_1s(tick_1s), .rd_addr(rd_addr5),
      .rd_data(rd_data5), .cursor(cursor5), .player(player5), .state(state5),
      .winner(winner5), .illegal(illegal5), .timeout(timeout5),
      .score_x(score_x5), .score_o(score_o5)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One-cycle pulse of the given inputs; returns on the falling edge right
   // after the rising edge that consumed them.
   task automatic step(input logic bn, input logic bs, input logic ng, input logic tk);
      @(negedge clk);
      btn_next = bn; btn_sel = bs; new_game = ng; tick_1s = tk;
      @(negedge clk);
      btn_next = 1'b0; btn_sel = 1'b0; new_game = 1'b0; tick_1s = 1'b0;
   endtask

   task automatic wait3();
      int n = 0;
      while (state3 == 2'b01 && n < 100) begin @(negedge clk); n++; end
      last_cyc = n;
      if (n >= 100) check("check3_bound", state3, 2'b00);
   endtask

   task automatic wait5();
      int n = 0;
      while (state5 == 2'b01 && n < 100) begin @(negedge clk); n++; end
      last_cyc = n;
      if (n >= 100) check("check5_bound", state5, 2'b00);
   endtask

   task automatic place3(input int k);
      while (c3 != k) begin step(1'b1, 1'b0, 1'b0, 1'b0); c3 = (c3 + 1) % 9; end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      wait3();
   endtask

   task automatic place5(input int k);
      while (c5 != k) begin step(1'b1, 1'b0, 1'b0, 1'b0); c5 = (c5 + 1) % 25; end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      wait5();
   endtask

   task automatic rd3(input string tag, input int a, input int e);
      @(negedge clk);
      rd_addr3 = 4'(a);
      @(negedge clk);
      check(tag, rd_data3, 32'(e));
   endtask

   task automatic rd5(input string tag, input int a, input int e);
      @(negedge clk);
      rd_addr5 = 5'(a);
      @(negedge clk);
      check(tag, rd_data5, 32'(e));
   endtask

   initial begin
      // ---------------- reset values ----------------
      repeat (2) @(negedge clk);
      check("rst_state",   state3,   0);
      check("rst_cursor",  cursor3,  0);
      check("rst_player",  player3,  0);
      check("rst_winner",  winner3,  0);
      check("rst_illegal", illegal3, 0);
      check("rst_timeout", timeout3, 0);
      check("rst_score_x", score_x3, 0);
      check("rst_score_o", score_o3, 0);
      check("rst_rd_data", rd_data3, 0);

      // First input honoured on the first edge after release.
      rst = 1'b1; btn_next = 1'b1;
      @(negedge clk);
      btn_next = 1'b0;
      check("first_edge_cursor3", cursor3, 1);
      check("first_edge_cursor5", cursor5, 1);

      // ---------------- X wins the top row ----------------
      step(1'b0, 1'b0, 1'b1, 1'b0); c3 = 0;
      check("ng_cursor", cursor3, 0);
      place3(0);
      check("x0_state",  state3,  0);
      check("x0_player", player3, 1);
      place3(3); place3(1); place3(4); place3(2);
      check("row_state",   state3,   2);
      check("row_winner",  winner3,  1);
      check("row_score_x", score_x3, 1);
      check("row_score_o", score_o3, 0);
      check("row_player",  player3,  0);
      rd3("row_cell2", 2, 1);
      rd3("row_cell3", 3, 2);
      rd3("row_cell8", 8, 0);
      rd3("rd_oob9",   9, 0);
      rd3("rd_oob15", 15, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("win_next_ignored", cursor3, 2);

      // ---------------- illegal select, select+next ----------------
      step(1'b0, 1'b0, 1'b1, 1'b0); c3 = 0;
      place3(4);
      check("il_player_before", player3, 1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("il_pulse", illegal3, 1);
      check("il_state", state3,   0);
      @(negedge clk);
      check("il_pulse_end", illegal3, 0);
      check("il_player",    player3,  1);
      rd3("il_cell4", 4, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0); c3 = 5;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("selnext_cursor", cursor3, 5);
      check("selnext_state",  state3,  1);
      wait3();
      rd3("selnext_cell5", 5, 2);
      check("selnext_player", player3, 0);

      // ---------------- draw ----------------
      step(1'b0, 1'b0, 1'b1, 1'b0); c3 = 0;
      place3(0); place3(1); place3(2); place3(4); place3(3);
      place3(5); place3(7); place3(6); place3(8);
      check("draw_state",   state3,   3);
      check("draw_winner",  winner3,  0);
      check("draw_score_x", score_x3, 1);
      check("draw_score_o", score_o3, 0);
      check("draw_player",  player3,  0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("draw_sel_state",   state3,   3);
      check("draw_sel_illegal", illegal3, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("draw_next_cursor", cursor3, 8);

      // ---------------- turn timeout (2 ticks) ----------------
      step(1'b0, 1'b0, 1'b1, 1'b0); c3 = 0;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("to_tick1",        timeout3, 0);
      check("to_tick1_player", player3,  0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("to_tick2",        timeout3, 1);
      check("to_tick2_player", player3,  1);
      @(negedge clk);
      check("to_pulse_end", timeout3, 0);
      rd3("to_board", 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("to_sel_no_timeout", timeout3, 0);
      check("to_sel_state",      state3,   1);
      wait3();
      check("to_sel_player", player3, 0);
      rd3("to_sel_cell0", 0, 2);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("to_restart", timeout3, 0);

      // ---------------- 5x5, four on the anti-diagonal ----------------
      step(1'b0, 1'b0, 1'b1, 1'b0); c5 = 0;
      place5(3); place5(4); place5(7); place5(8); place5(11);
      check("ad3_state",  state5,  0);
      check("ad3_player", player5, 1);
      place5(12); place5(15);
      check("ad4_state",   state5,   2);
      check("ad4_winner",  winner5,  1);
      check("ad4_score_x", score_x5, 1);
      check("ad4_latency", 32'(last_cyc <= 26), 1);
      rd5("ad4_cell15", 15, 1);
      rd5("ad4_cell12", 12, 2);
      rd5("rd5_oob25",  25, 0);

      // ---------------- score saturation ----------------
      // X wins down column 0 (0,3,6) while O plays 1,4.
      repeat (254) begin
         step(1'b0, 1'b0, 1'b1, 1'b0); c3 = 0;
         place3(0); place3(1); place3(3); place3(4); place3(6);
      end
      check("sat_255", score_x3, 255);
      step(1'b0, 1'b0, 1'b1, 1'b0); c3 = 0;
      place3(0); place3(1); place3(3); place3(4); place3(6);
      check("sat_state",   state3,   2);
      check("sat_hold",    score_x3, 255);
      check("sat_score_o", score_o3, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0); c3 = 0;
      check("ng_keep_x", score_x3, 255);
      check("ng_state",  state3,   0);
      check("ng_winner", winner3,  0);
      rd3("ng_cell0", 0, 0);
      rd3("ng_cell6", 6, 0);

      // ---------------- asynchronous reset clears scores ----------------
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_score_x", score_x3, 0);
      check("arst_state",   state3,   0);
      check("arst_rd_data", rd_data3, 0);
      check("arst_score_x5", score_x5, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
